// File: rtl/scc_mixer_n.sv
// N-cartridge SCC output stage: chip-select decode, read-back merge,
// and a single-multiplier gain/accumulate mixer with a saturated output.
module scc_mixer_n #(
    parameter int NUM_CH = 2,
    parameter int CART_W = 1,
    parameter int IN_W   = 15,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clk_en,
    input  logic                     cs,
    input  logic [CART_W-1:0]        cart_num,
    output logic [NUM_CH-1:0]        req,
    input  logic [8*NUM_CH-1:0]      ch_dout,
    output logic [7:0]               scc_dout,
    input  logic [IN_W*NUM_CH-1:0]   ch_wave,
    input  logic [NUM_CH-1:0]        oe,
    input  logic [GAIN_W*NUM_CH-1:0] gain,
    output logic [OUT_W-1:0]         wave,
    output logic                     wave_valid,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = IN_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
    localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [CMP_W-1:0] SAT_MAX =
        {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN =
        {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic                     start;
    logic                     last;
    logic                     pending;
    logic [IDX_W-1:0]         idx;
    logic [IN_W*NUM_CH-1:0]   wave_s;
    logic [NUM_CH-1:0]        oe_s;
    logic [GAIN_W*NUM_CH-1:0] gain_s;

    logic signed [IN_W-1:0]   wave_sel;
    logic [GAIN_W-1:0]        gain_sel;
    logic signed [PROD_W-1:0] w_x;
    logic signed [PROD_W-1:0] g_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] term;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nx;
    logic signed [ACC_W-1:0]  res;
    logic signed [CMP_W-1:0]  res_x;
    logic [OUT_W-1:0]         wave_d;

    // One request line per instance; out-of-range cart_num selects none.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = cs && (int'(cart_num) == i);
        end
    end

    // Idle instances drive FF, so an AND merges the read-back buses.
    always_comb begin
        scc_dout = 8'hFF;
        for (int i = 0; i < NUM_CH; i++) begin
            scc_dout = scc_dout & ch_dout[i*8 +: 8];
        end
    end

    assign busy = (state != S_IDLE);
    assign last = (idx == IDX_W'(NUM_CH - 1));

    assign wave_sel = wave_s[int'(idx)*IN_W +: IN_W];
    assign gain_sel = gain_s[int'(idx)*GAIN_W +: GAIN_W];
    assign w_x      = PROD_W'(wave_sel);
    assign g_x      = PROD_W'({1'b0, gain_sel});
    assign prod     = w_x * g_x;
    assign term     = oe_s[idx] ? prod : '0;
    assign acc_nx   = acc + ACC_W'(term);
    assign res      = acc >>> (GAIN_W - 1);
    assign res_x    = CMP_W'(res);

    // Clamp the scaled sum into the output range.
    always_comb begin
        wave_d = res_x[OUT_W-1:0];
        if (res_x > SAT_MAX) begin
            wave_d = SAT_MAX[OUT_W-1:0];
        end else if (res_x < SAT_MIN) begin
            wave_d = SAT_MIN[OUT_W-1:0];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: start on a strobe or a queued strobe, one channel per cycle.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (clk_en || pending) begin
                    start    = 1'b1;
                    state_nx = S_ACC;
                end
            end
            S_ACC: begin
                if (last) begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Snapshot inputs at start, then accumulate the selected channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave_s <= '0;
            oe_s   <= '0;
            gain_s <= '0;
            acc    <= '0;
            idx    <= '0;
        end else if (start) begin
            wave_s <= ch_wave;
            oe_s   <= oe;
            gain_s <= gain;
            acc    <= '0;
            idx    <= '0;
        end else if (state == S_ACC) begin
            acc <= acc_nx;
            if (!last) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Register the saturated sample and strobe it for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave       <= '0;
            wave_valid <= 1'b0;
        end else begin
            wave_valid <= (state == S_OUT);
            if (state == S_OUT) begin
                wave <= wave_d;
            end
        end
    end

    // One strobe may queue while busy; a second one is lost and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start) begin
                pending <= 1'b0;
            end else if (clk_en && busy && !pending) begin
                pending <= 1'b1;
            end
            if (clk_en && busy && pending) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scc_mixer_n.sv
// Bench for scc_mixer_n: timeline model of the mixer plus
// hand-computed sample values for directed vectors.
module tb_scc_mixer_n;

    localparam int NC     = 2;
    localparam int IN_W   = 15;
    localparam int OUT_W  = 16;
    localparam int GAIN_W = 4;
    localparam int WW     = IN_W * NC;
    localparam int GW     = GAIN_W * NC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n     = 1'b1;
    logic             clk_en      = 1'b0;
    logic             cs          = 1'b0;
    logic             overrun_clr = 1'b0;
    logic [0:0]       cart_num    = '0;
    logic [1:0]       cart_num2   = '0;
    logic [8*NC-1:0]  ch_dout     = '1;
    logic [WW-1:0]    ch_wave     = '0;
    logic [NC-1:0]    oe          = '0;
    logic [GW-1:0]    gain        = '0;

    logic [NC-1:0]    req, req2;
    logic [7:0]       scc_dout, scc_dout2;
    logic [OUT_W-1:0] wave, wave2;
    logic             wave_valid, busy, overrun;
    logic             wv2, busy2, ovr2;

    scc_mixer_n #(.NUM_CH(NC), .CART_W(1)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cs(cs),
        .cart_num(cart_num), .req(req), .ch_dout(ch_dout),
        .scc_dout(scc_dout), .ch_wave(ch_wave), .oe(oe), .gain(gain),
        .wave(wave), .wave_valid(wave_valid), .busy(busy),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    scc_mixer_n #(.NUM_CH(NC), .CART_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cs(cs),
        .cart_num(cart_num2), .req(req2), .ch_dout(ch_dout),
        .scc_dout(scc_dout2), .ch_wave(ch_wave), .oe(oe), .gain(gain),
        .wave(wave2), .wave_valid(wv2), .busy(busy2),
        .overrun(ovr2), .overrun_clr(overrun_clr)
    );

    int checks   = 0;
    int failures = 0;
    int npulse   = 0;
    int p0;

    // Mixed sample from the arithmetic definition: gain-weighted sum, /2^(G-1) floor, clamp.
    function automatic int mix(logic [WW-1:0] w, logic [NC-1:0] o,
                               logic [GW-1:0] g);
        longint s = 0;
        for (int i = 0; i < NC; i++) begin
            if (o[i]) begin
                s += longint'($signed(w[i*IN_W +: IN_W]))
                   * longint'(g[i*GAIN_W +: GAIN_W]);
            end
        end
        s = s >>> (GAIN_W - 1);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic logic [NC-1:0] req_m(logic c, int cn);
        logic [NC-1:0] r = '0;
        for (int i = 0; i < NC; i++) r[i] = c && (cn == i);
        return r;
    endfunction

    function automatic logic [7:0] and_m(logic [8*NC-1:0] d);
        logic [7:0] r = 8'hFF;
        for (int i = 0; i < NC; i++) r = r & d[i*8 +: 8];
        return r;
    endfunction

    // Model: the mixer is occupied for NC+2 cycles per sample and holds one queued strobe.
    int cnt     = 0;
    int free_at = 0;
    int exp_at  = -1;
    int exp_v   = 0;
    int mwave   = 0;
    bit mpend   = 1'b0;
    bit movr    = 1'b0;
    bit mvalid  = 1'b0;
    bit m_idle;
    bit m_set;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt = 0; free_at = 0; exp_at = -1; mwave = 0;
            mpend = 1'b0; movr = 1'b0; mvalid = 1'b0;
        end else begin
            m_idle = (cnt >= free_at);
            m_set  = 1'b0;
            if (m_idle && (mpend || clk_en)) begin
                exp_v   = mix(ch_wave, oe, gain);
                exp_at  = cnt + NC + 2;
                free_at = cnt + NC + 2;
                mpend   = 1'b0;
            end else if (!m_idle && clk_en) begin
                if (mpend) m_set = 1'b1;
                else mpend = 1'b1;
            end
            if (m_set) movr = 1'b1;
            else if (overrun_clr) movr = 1'b0;
            cnt++;
            mvalid = (cnt == exp_at);
            if (mvalid) mwave = exp_v;
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        chk("cyc_valid", wave_valid, mvalid);
        chk("cyc_wave", $signed(wave), mwave);
        chk("cyc_busy", busy, cnt < free_at);
        chk("cyc_overrun", overrun, movr);
        chk("cyc_req", req, req_m(cs, int'(cart_num)));
        chk("cyc_dout", scc_dout, and_m(ch_dout));
        chk("cyc_valid2", wv2, mvalid);
        chk("cyc_wave2", $signed(wave2), mwave);
        chk("cyc_busy2", busy2, cnt < free_at);
        chk("cyc_overrun2", ovr2, movr);
        chk("cyc_req2", req2, req_m(cs, int'(cart_num2)));
        chk("cyc_dout2", scc_dout2, and_m(ch_dout));
        if (wave_valid) npulse++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp_cycle();
    endtask

    task automatic set_ch(int w0, int w1, int g0, int g1, logic [NC-1:0] o);
        ch_wave = {IN_W'(w1), IN_W'(w0)};
        gain    = {GAIN_W'(g1), GAIN_W'(g0)};
        oe      = o;
    endtask

    // Single strobe; inputs are scrambled right after to prove only the snapshot counts.
    task automatic run(string nm, int w0, int w1, int g0, int g1,
                       logic [NC-1:0] o, int lit);
        set_ch(w0, w1, g0, g1, o);
        clk_en = 1'b1;
        tick();
        clk_en  = 1'b0;
        ch_wave = WW'($urandom);
        gain    = GW'($urandom);
        oe      = NC'($urandom);
        p0 = npulse;
        repeat (3) tick();
        chk({nm, "_wave"}, $signed(wave), lit);
        chk({nm, "_valid"}, wave_valid, 1);
        repeat (3) tick();
        chk({nm, "_pulses"}, npulse - p0, 1);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_wave", wave, 0);
        chk("rst_valid", wave_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        #2 reset_n = 1'b1;
        tick();

        cs = 1'b1; cart_num = 1'b1; cart_num2 = 2'd3;
        ch_dout = 16'hF03C;
        #1;
        chk("dec_req", req, 2'b10);
        chk("dec_dout", scc_dout, 8'h30);
        chk("dec_req_oor", req2, 2'b00);
        cart_num2 = 2'd1;
        #1 chk("dec_req2", req2, 2'b10);
        cs = 1'b0;
        #1 chk("dec_cs0", req, 2'b00);
        tick();
        ch_dout = '1;
        tick();

        run("unity",   1000,   -300,  8,  8, 2'b11,    700);
        run("sat_pos", 16383,  16383, 15, 15, 2'b11,  32767);
        run("sat_neg", -16384, -16384, 15, 15, 2'b11, -32768);
        run("mask",    800,    5000,  4,  8, 2'b01,    400);
        run("gain0",   800,    5000,  0,  8, 2'b01,      0);
        run("floor",   -3,     0,     1,  0, 2'b01,     -1);
        run("oe0",     1000,   1000,  8,  8, 2'b00,      0);

        set_ch(1000, -300, 8, 8, 2'b11);
        p0 = npulse;
        overrun_clr = 1'b1;
        clk_en = 1'b1;
        tick();
        set_ch(2000, -300, 8, 8, 2'b11);
        tick();
        tick();
        clk_en = 1'b0;
        overrun_clr = 1'b0;
        chk("b2b_overrun_setwins", overrun, 1);
        tick();
        chk("b2b_first", $signed(wave), 700);
        repeat (4) tick();
        chk("b2b_second", $signed(wave), 1700);
        chk("b2b_second_valid", wave_valid, 1);
        repeat (4) tick();
        chk("b2b_pulses", npulse - p0, 2);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("b2b_clr", overrun, 0);

        set_ch(1000, -300, 8, 8, 2'b11);
        clk_en = 1'b1;
        repeat (3) tick();
        clk_en = 1'b0;
        repeat (2) tick();
        chk("mid_busy", busy, 1);
        chk("mid_overrun", overrun, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wave", wave, 0);
        chk("mid_rst_valid", wave_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        p0 = npulse;
        repeat (10) tick();
        chk("post_rst_nopulse", npulse - p0, 0);

        run("post_rst", 1000, -300, 8, 8, 2'b11, 700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scc_mixer_n.md
Name: scc_mixer_n

Overview:
- Parametrised N-cartridge SCC output stage for the slot subsystem.
- Decodes the cartridge chip-select into one request line per SCC instance and AND-combines the instances' read-back buses.
- Mixes the SCC waves through a time-multiplexed gain/accumulate sequencer (one multiplier) and drives a saturated, registered mono sample with a valid strobe.
- Replaces the fixed two-instance, unity-gain, unsaturated sum.

Parameters:
NUM_CH, 2, number of SCC instances mixed (1..8)
CART_W, 1, width of cart_num
IN_W, 15, signed width of each instance wave
OUT_W, 16, signed width of mixed output
GAIN_W, 4, unsigned per-channel gain width; unity = 2**(GAIN_W-1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_en  in  1  sample strobe, one clk wide
cs  in  1  SCC region chip-select
cart_num  in  CART_W  selected cartridge index
req  out  NUM_CH  per-instance request
ch_dout  in  8*NUM_CH  per-instance read data; idle instances drive FF
scc_dout  out  8  combined read data
ch_wave  in  IN_W*NUM_CH  per-instance signed wave, channel 0 in LSBs
oe  in  NUM_CH  per-channel output enable
gain  in  GAIN_W*NUM_CH  per-channel unsigned gain
wave  out  OUT_W  signed mixed sample, registered
wave_valid  out  1  one-cycle pulse when wave updates
busy  out  1  sequencer not IDLE
overrun  out  1  sticky; a strobe was lost
overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0:
  - wave=0, wave_valid=0, busy=0, overrun=0.
  - State=IDLE, pending=0, accumulator=0, channel counter=0.
- Combinational decode:
  - req[i] = cs & (cart_num == i).
  - cart_num >= NUM_CH asserts no req.
  - scc_dout = bitwise AND of all ch_dout slices.
- States: IDLE, ACC, OUT.
- IDLE:
  - clk_en=1 or pending=1 -> snapshot ch_wave, oe and gain into registers, clear pending, acc=0, idx=0, go to ACC.
- ACC, one channel per cycle:
  - acc += oe_s[idx] ? signed(wave_s[idx]) * unsigned(gain_s[idx]) : 0.
  - idx == NUM_CH-1 -> go to OUT; otherwise idx++.
- OUT:
  - res = acc >>> (GAIN_W-1), arithmetic shift.
  - Saturate res to OUT_W: clamp to 2**(OUT_W-1)-1 or -2**(OUT_W-1).
  - Register the result into wave, pulse wave_valid for exactly this cycle, go to IDLE.
- Accumulator width: IN_W+GAIN_W+1+clog2(NUM_CH). No internal overflow is possible; saturation happens only at OUT.
- Latency: clk_en accepted in IDLE at cycle T -> wave/wave_valid visible at T+NUM_CH+2.
- Minimum strobe spacing for lossless operation: NUM_CH+2 clocks.
- clk_en while busy=1:
  - pending=0 -> set pending; the next sequence starts on the first IDLE cycle.
  - pending=1 -> strobe dropped, overrun set.
- overrun_clr and a new overrun event in the same cycle -> overrun stays 1 (set wins).
- Input changes during ACC do not affect the current result; only snapshots are used.
- gain=0 or oe=0 -> channel contributes exactly 0.
- wave holds its value between updates.
- Reset mid-sequence aborts; no wave_valid is issued.
- busy=1 in ACC and OUT.

Test Plan:
- Unity mix, defaults: ch0=1000, ch1=-300, gain=8/8, oe=11, clk_en pulse -> wave=700 with wave_valid 4 clocks later, single pulse.
- Saturation: ch0=ch1=16383, gain=15/15 -> wave=32767. Both -16384 -> wave=-32768.
- Masking/gain: oe=01, ch0=800, gain0=4, ch1=5000 -> wave=400. gain0=0 -> wave=0.
- Back-to-back strobes at clocks 0, 1, 2:
  - first strobe runs; second sets pending; third sets overrun.
  - exactly two wave_valid pulses occur.
  - overrun_clr returns overrun to 0.
- Decode: cs=1, cart_num=1 -> req=10; ch_dout = {F0, 3C} -> scc_dout=30. With CART_W=2, NUM_CH=2 and cart_num=3 -> req=00.
- Reset: assert reset_n=0 during ACC -> all outputs zero immediately. After release, no wave_valid until a new clk_en.
